freelist: RTL and testbench
===========================

Name: freelist

Overview:
- Physical-register free list for the 4-wide rename/dispatch path.
- Sits downstream of the ROB commit port: it takes the stale physical destinations released at commit and returns them to the pool.
- It also sits upstream of dispatch: each cycle it offers up to 4 free physical registers to rename for the next dispatch group.
- Implemented as a circular FIFO of register tags with multi-entry push/pop per cycle.

Parameters:
- WIDTH_REG, 7, physical register tag width; NPREG = 2**WIDTH_REG physical registers.
- NARCH, 32, architectural registers; tags 0..NARCH-1 are mapped at reset and never appear in the list at reset.
- DEPTH (derived, localparam), NPREG-NARCH = 96, FIFO capacity.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_alloc_mask4x  in  4  slot k needs a destination register (rd != x0); bit k = slot k.
- i_alloc_en  in  1  dispatch group accepted this cycle; pop the allocated tags.
- o_alloc_prd4x  out  4*WIDTH_REG  tag for slot k at bits [k*WIDTH_REG +: WIDTH_REG].
- o_alloc_rdy  out  1  at least popcount(i_alloc_mask4x) tags available.
- i_free_prd4x  in  4*WIDTH_REG  stale tags released at commit, same packing.
- i_free_mask4x  in  4  slot k of i_free_prd4x is valid.
- i_free_en  in  1  commit strobe (driven from ROB commit-enable).
- o_free_cnt  out  WIDTH_REG+1  number of tags currently in the list.
- o_ovf  out  1  sticky error: free attempted beyond capacity.

Behaviour:
- State:
  - mem[0:DEPTH-1] of WIDTH_REG bits.
  - head and tail, each 0..DEPTH-1, wrapping explicitly modulo DEPTH (DEPTH need not be a power of two).
  - cnt, 0..DEPTH.
- Reset, synchronous, when i_rst=1 at an edge:
  - mem[j] = NARCH+j; head=0; tail=0 (full ring, tail==head); cnt=DEPTH; o_ovf=0.
  - Reset overrides any alloc/free in the same cycle.
  - Reset mid-operation discards all in-flight state.
- Allocation presentation (combinational from current state):
  - Let n_a = popcount(i_alloc_mask4x).
  - Slot k with mask bit set gets mem[(head + popcount(mask[k-1:0])) mod DEPTH].
  - Masked-off slots drive 0.
  - o_alloc_rdy = (cnt >= n_a); n_a=0 gives rdy=1.
- Pop: on the edge with i_alloc_en=1 and o_alloc_rdy=1:
  - head += n_a mod DEPTH; cnt -= n_a.
  - i_alloc_en=1 with o_alloc_rdy=0 is ignored: no pop and no state change. Dispatch must stall.
- Push: on the edge with i_free_en=1:
  - Let n_f = popcount(i_free_mask4x).
  - Valid slots are written in ascending slot order at tail, tail+1, ... mod DEPTH.
  - tail += n_f; cnt += n_f.
- Simultaneous pop and push in one cycle:
  - Both apply: cnt_next = cnt - n_a + n_f.
  - No bypass: tags freed in cycle t are visible on o_alloc_prd4x from cycle t+1 at the earliest.
- Overflow:
  - Condition: cnt - (popped n_a) + n_f > DEPTH.
  - The entire push is dropped (the pop still applies) and o_ovf is set; o_ovf holds until reset.
  - Cannot occur with a correct core; it is a verification hook.
- o_free_cnt = cnt (registered).
- Latency: allocation is 0-cycle combinational from state; state is updated 1 cycle after the strobe.

Test Plan:
- Reset then observe: o_free_cnt=96, mask=4'b1111 -> o_alloc_prd4x slots = 32,33,34,35, o_alloc_rdy=1, o_ovf=0.
- Sparse mask 4'b1010 with alloc_en -> slot1=32, slot3=33, slots0/2=0. Next cycle with mask 4'b1111 -> 34,35,36,37 and cnt=94.
- Drain: allocate 4/cycle for 24 cycles -> cnt=0. Mask 4'b0001 -> rdy=0, and alloc_en produces no state change. Mask 4'b0000 -> rdy=1.
- Wrap: from empty, free tags {5,9,—,7} with mask 4'b1011 -> cnt=3. Then alloc 4'b0111 -> 5,9,7 in that order. Repeat across index 95 -> 0 and check order is preserved.
- Simultaneous: with cnt=2 (tags 40,41), alloc 4'b0011 and free {50} mask 4'b0001 in the same cycle -> outputs 40,41, cnt_next=1, next head tag=50.
- Overflow/reset: at cnt=96 free mask 4'b0001 -> cnt stays 96, o_ovf=1 sticky. Assert i_rst together with alloc_en -> state is back to reset values and o_ovf=0.

Source files
------------

// File: rtl/freelist_if.sv
// freelist_if: rename/commit side bundle of the physical-register free list.
//   i_alloc_mask4x  slots of the dispatch group that need a destination tag
//   i_alloc_en      dispatch group accepted; pop the offered tags
//   o_alloc_prd4x   offered tags, slot k at [k*WIDTH_REG +: WIDTH_REG]
//   o_alloc_rdy     enough tags for every requesting slot
//   i_free_prd4x    stale tags released at commit, same packing
//   i_free_mask4x   valid slots of i_free_prd4x
//   i_free_en       commit strobe
//   o_free_cnt      tags currently held in the list
//   o_ovf           sticky overflow error
// master = rename/commit logic, slave = free list.
interface freelist_if #(
  parameter int WIDTH_REG = 7
);
  logic [3:0]             i_alloc_mask4x;
  logic                   i_alloc_en;
  logic [4*WIDTH_REG-1:0] o_alloc_prd4x;
  logic                   o_alloc_rdy;
  logic [4*WIDTH_REG-1:0] i_free_prd4x;
  logic [3:0]             i_free_mask4x;
  logic                   i_free_en;
  logic [WIDTH_REG:0]     o_free_cnt;
  logic                   o_ovf;

  modport master (
    output i_alloc_mask4x, i_alloc_en, i_free_prd4x, i_free_mask4x, i_free_en,
    input  o_alloc_prd4x, o_alloc_rdy, o_free_cnt, o_ovf
  );

  modport slave (
    input  i_alloc_mask4x, i_alloc_en, i_free_prd4x, i_free_mask4x, i_free_en,
    output o_alloc_prd4x, o_alloc_rdy, o_free_cnt, o_ovf
  );
endinterface

// File: rtl/freelist.sv
// freelist: circular FIFO of free physical register tags for a 4-wide
// rename path. Up to 4 tags are offered combinationally to dispatch each
// cycle and popped on acceptance; up to 4 stale tags are pushed at commit.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  synchronous active-high reset (list refilled with NARCH..NPREG-1)
//   bus    freelist_if slave: alloc request/offer, free push, count, overflow
module freelist #(
  parameter int WIDTH_REG = 7,
  parameter int NARCH     = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  freelist_if.slave  bus
);
  localparam int NPREG = 1 << WIDTH_REG;
  localparam int DEPTH = NPREG - NARCH;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = WIDTH_REG + 1;

  logic [WIDTH_REG-1:0] mem_q [DEPTH];
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  // a_off[k] / f_off[k]: number of set mask bits below slot k; [4] = total.
  logic [2:0]           a_off [5];
  logic [2:0]           f_off [5];
  logic [PW-1:0]        rd_idx [4];
  logic [PW-1:0]        wr_idx [4];
  logic [WIDTH_REG-1:0] free_tag [4];

  logic                 alloc_rdy;
  logic                 pop;
  logic                 push;
  logic                 ovf_hit;
  logic [CW-1:0]        cnt_after_pop;
  logic [CW:0]          cnt_sum;

  // Ring index advance; DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                             input logic [2:0] off);
    logic [PW:0] s;
    s = {1'b0, base} + (PW+1)'(off);
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  always_comb begin
    a_off[0] = '0;
    f_off[0] = '0;
    for (int k = 0; k < 4; k++) begin
      a_off[k+1] = a_off[k] + {2'b00, bus.i_alloc_mask4x[k]};
      f_off[k+1] = f_off[k] + {2'b00, bus.i_free_mask4x[k]};
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    assign rd_idx[gi]   = wrap_add(head_q, a_off[gi]);
    assign wr_idx[gi]   = wrap_add(tail_q, f_off[gi]);
    assign free_tag[gi] = bus.i_free_prd4x[gi*WIDTH_REG +: WIDTH_REG];
    assign bus.o_alloc_prd4x[gi*WIDTH_REG +: WIDTH_REG] =
      bus.i_alloc_mask4x[gi] ? mem_q[rd_idx[gi]] : '0;
  end

  assign alloc_rdy = (cnt_q >= CW'(a_off[4]));
  assign pop       = bus.i_alloc_en & alloc_rdy;

  // Overflow is judged against the count left after this cycle's pop, so a
  // full list may still accept a push that is matched by an allocation.
  always_comb begin
    cnt_after_pop = pop ? (cnt_q - CW'(a_off[4])) : cnt_q;
    cnt_sum       = {1'b0, cnt_after_pop} + (CW+1)'(f_off[4]);
    ovf_hit       = bus.i_free_en & (cnt_sum > (CW+1)'(DEPTH));
    push          = bus.i_free_en & ~ovf_hit;
    head_d        = pop  ? wrap_add(head_q, a_off[4]) : head_q;
    tail_d        = push ? wrap_add(tail_q, f_off[4]) : tail_q;
    cnt_d         = push ? cnt_sum[CW-1:0] : cnt_after_pop;
    ovf_d         = ovf_q | ovf_hit;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= WIDTH_REG'(NARCH + j);
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= CW'(DEPTH);
      ovf_q  <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push && bus.i_free_mask4x[k]) begin
          mem_q[wr_idx[k]] <= free_tag[k];
        end
      end
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.o_alloc_rdy = alloc_rdy;
  assign bus.o_free_cnt  = cnt_q;
  assign bus.o_ovf       = ovf_q;
endmodule

// File: tb/tb_freelist.sv
// tb_freelist: table-driven vectors plus hand-written corner sequences.
// A queue-based reference free list produces expected outputs each cycle;
// these are pushed to a scoreboard when stimulus is driven and popped when
// the DUT outputs are sampled on the falling edge.
module tb_freelist;
  localparam int W = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  freelist_if #(.WIDTH_REG(W)) bus ();

  freelist #(.WIDTH_REG(W), .NARCH(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [4*W-1:0] prd;
    logic [4*W-1:0] care;
    logic           rdy;
    logic [W:0]     cnt;
    logic           ovf;
  } exp_t;

  typedef struct {
    logic [3:0]     am;
    logic           ae;
    logic [4*W-1:0] fp;
    logic [3:0]     fm;
    logic           fe;
    logic [4*W-1:0] exp_prd;
    logic           exp_rdy;
    logic [W:0]     exp_cnt;
  } vec_t;

  exp_t sb_q[$];
  int   fl_q[$];
  logic ovf_m;

  int checks = 0;
  int passed = 0;

  logic [4*W-1:0] s_prd;
  logic           s_rdy;
  logic [W:0]     s_cnt;
  logic           s_ovf;

  function automatic logic [4*W-1:0] pack4(input int a, input int b,
                                           input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  function automatic exp_t model_expect(input logic [3:0] am);
    exp_t e;
    int idx;
    idx = 0;
    e.prd = '0;
    e.care = '0;
    for (int k = 0; k < 4; k++) begin
      if (!am[k]) begin
        e.care[k*W +: W] = '1;
      end else begin
        if (idx < fl_q.size()) begin
          e.prd[k*W +: W]  = W'(fl_q[idx]);
          e.care[k*W +: W] = '1;
        end
        idx++;
      end
    end
    e.rdy = (fl_q.size() >= idx);
    e.cnt = (W+1)'(fl_q.size());
    e.ovf = ovf_m;
    return e;
  endfunction

  task automatic model_reset();
    fl_q.delete();
    for (int j = 0; j < 96; j++) fl_q.push_back(32 + j);
    ovf_m = 1'b0;
  endtask

  task automatic model_update(input logic r, input logic [3:0] am,
                              input logic ae, input logic [4*W-1:0] fp,
                              input logic [3:0] fm, input logic fe);
    int na, nf;
    if (r) begin
      model_reset();
      return;
    end
    na = $countones(am);
    nf = $countones(fm);
    if (ae && fl_q.size() >= na)
      for (int i = 0; i < na; i++) void'(fl_q.pop_front());
    if (fe) begin
      if (fl_q.size() + nf > 96) ovf_m = 1'b1;
      else
        for (int k = 0; k < 4; k++)
          if (fm[k]) fl_q.push_back(int'(fp[k*W +: W]));
    end
  endtask

  // One clock: drive, predict, sample at negedge, compare, advance model.
  task automatic cyc(input logic r, input logic [3:0] am, input logic ae,
                     input logic [4*W-1:0] fp, input logic [3:0] fm,
                     input logic fe);
    exp_t g;
    rst = r;
    bus.i_alloc_mask4x = am;
    bus.i_alloc_en     = ae;
    bus.i_free_prd4x   = fp;
    bus.i_free_mask4x  = fm;
    bus.i_free_en      = fe;
    sb_q.push_back(model_expect(am));
    @(negedge clk);
    s_prd = bus.o_alloc_prd4x;
    s_rdy = bus.o_alloc_rdy;
    s_cnt = bus.o_free_cnt;
    s_ovf = bus.o_ovf;
    g = sb_q.pop_front();
    chk("sb_prd", 32'(s_prd & g.care), 32'(g.prd));
    chk("sb_rdy", 32'(s_rdy), 32'(g.rdy));
    chk("sb_cnt", 32'(s_cnt), 32'(g.cnt));
    chk("sb_ovf", 32'(s_ovf), 32'(g.ovf));
    @(posedge clk);
    model_update(r, am, ae, fp, fm, fe);
    #1;
  endtask

  task automatic idle(input logic [3:0] am);
    cyc(1'b0, am, 1'b0, '0, 4'b0000, 1'b0);
  endtask

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [4*W-1:0] tags;

    vecs[0] = '{4'b1111, 1'b0, '0, 4'b0000, 1'b0, pack4(32, 33, 34, 35), 1'b1, 8'd96};
    vecs[1] = '{4'b1010, 1'b1, '0, 4'b0000, 1'b0, pack4(0, 32, 0, 33), 1'b1, 8'd96};
    vecs[2] = '{4'b1111, 1'b1, '0, 4'b0000, 1'b0, pack4(34, 35, 36, 37), 1'b1, 8'd94};
    vecs[3] = '{4'b0001, 1'b0, pack4(3, 0, 0, 0), 4'b0001, 1'b1, pack4(38, 0, 0, 0), 1'b1, 8'd90};
    vecs[4] = '{4'b0000, 1'b0, '0, 4'b0000, 1'b0, '0, 1'b1, 8'd91};

    bus.i_alloc_mask4x = '0;
    bus.i_alloc_en     = 1'b0;
    bus.i_free_prd4x   = '0;
    bus.i_free_mask4x  = '0;
    bus.i_free_en      = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state, sparse mask, push after pop.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, vecs[i].am, vecs[i].ae, vecs[i].fp, vecs[i].fm, vecs[i].fe);
      chk($sformatf("tbl%0d_prd", i), 32'(s_prd), 32'(vecs[i].exp_prd));
      chk($sformatf("tbl%0d_rdy", i), 32'(s_rdy), 32'(vecs[i].exp_rdy));
      chk($sformatf("tbl%0d_cnt", i), 32'(s_cnt), 32'(vecs[i].exp_cnt));
      chk($sformatf("tbl%0d_ovf", i), 32'(s_ovf), 0);
    end

    // Drain from reset, then stall on an empty list.
    cyc(1'b1, 4'b0000, 1'b0, '0, 4'b0000, 1'b0);
    for (int i = 0; i < 24; i++) cyc(1'b0, 4'b1111, 1'b1, '0, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0001, 1'b1, '0, 4'b0000, 1'b0);
    chk("drain_cnt", 32'(s_cnt), 0);
    chk("empty_rdy", 32'(s_rdy), 0);
    idle(4'b0000);
    chk("stall_cnt", 32'(s_cnt), 0);
    chk("zero_mask_rdy", 32'(s_rdy), 1);

    // Sparse free then ordered allocation.
    cyc(1'b0, 4'b0000, 1'b0, pack4(5, 9, 100, 7), 4'b1011, 1'b1);
    cyc(1'b0, 4'b0111, 1'b1, '0, 4'b0000, 1'b0);
    chk("wrap_cnt3", 32'(s_cnt), 3);
    chk("wrap_order", 32'(s_prd), 32'(pack4(5, 9, 7, 0)));

    // Repeated free/alloc pairs walk the ring past index 95 -> 0.
    for (int it = 0; it < 25; it++) begin
      tags = pack4($urandom_range(0, 127), $urandom_range(0, 127),
                   $urandom_range(0, 127), $urandom_range(0, 127));
      cyc(1'b0, 4'b0000, 1'b0, tags, 4'b1111, 1'b1);
      cyc(1'b0, 4'b1111, 1'b1, '0, 4'b0000, 1'b0);
      chk($sformatf("ring_order%0d", it), 32'(s_prd), 32'(tags));
    end

    // Simultaneous pop and push, no bypass of the freed tag.
    cyc(1'b0, 4'b0000, 1'b0, pack4(40, 41, 0, 0), 4'b0011, 1'b1);
    cyc(1'b0, 4'b0011, 1'b1, pack4(50, 0, 0, 0), 4'b0001, 1'b1);
    chk("simul_prd", 32'(s_prd), 32'(pack4(40, 41, 0, 0)));
    chk("simul_cnt", 32'(s_cnt), 2);
    idle(4'b0001);
    chk("simul_next_cnt", 32'(s_cnt), 1);
    chk("simul_next_tag", 32'(s_prd), 32'(pack4(50, 0, 0, 0)));

    // Full list: matched pop+push fits, a bare push overflows.
    cyc(1'b1, 4'b0000, 1'b0, '0, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0001, 1'b1, pack4(60, 0, 0, 0), 4'b0001, 1'b1);
    cyc(1'b0, 4'b0000, 1'b0, pack4(61, 0, 0, 0), 4'b0001, 1'b1);
    chk("full_swap_cnt", 32'(s_cnt), 96);
    chk("full_swap_ovf", 32'(s_ovf), 0);
    idle(4'b0000);
    chk("ovf_cnt", 32'(s_cnt), 96);
    chk("ovf_set", 32'(s_ovf), 1);
    idle(4'b1111);
    chk("ovf_sticky", 32'(s_ovf), 1);

    // Reset wins over a same-cycle allocation.
    cyc(1'b1, 4'b1111, 1'b1, '0, 4'b0000, 1'b0);
    idle(4'b1111);
    chk("rst_cnt", 32'(s_cnt), 96);
    chk("rst_ovf", 32'(s_ovf), 0);
    chk("rst_prd", 32'(s_prd), 32'(pack4(32, 33, 34, 35)));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
